// File: rtl/tlv_options_parser.sv
// tlv_options_parser
// Splits a TLV options area (one byte per beat) into kind/length/value
// records. It sits between the header extractor, which supplies the byte
// stream and the area length, and the option-consuming logic, which takes
// the records and the completion status.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i, total_len_i    begin an area of total_len_i bytes (sampled in READY)
//   in_valid/in_ready/in_data  byte stream, accepted on valid & ready
//   opt_valid/opt_ready     record handshake
//   opt_kind, opt_len       kind byte and raw length byte (1 for an emitted NOP)
//   opt_value, opt_trunc    value bytes (first byte in [7:0]) and overflow flag
//   busy                    parser is not idle
//   done                    one-cycle completion pulse
//   err, err_code           0 none, 1 bad length, 2 overrun, 3 too many options
//   opt_count               non-NOP records emitted for the current area
module tlv_options_parser #(
    parameter int LEN_W         = 6,
    parameter int MAX_VAL_BYTES = 8,
    parameter int MAX_OPTS      = 8,
    parameter int CNT_W         = 4,
    parameter bit EMIT_NOP      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [LEN_W-1:0]           total_len_i,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       opt_valid,
    input  logic                       opt_ready,
    output logic [7:0]                 opt_kind,
    output logic [7:0]                 opt_len,
    output logic [8*MAX_VAL_BYTES-1:0] opt_value,
    output logic                       opt_trunc,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [CNT_W-1:0]           opt_count
);

    typedef enum logic [2:0] {
        S_READY, S_START, S_INFO, S_LEN, S_DATA, S_END, S_DONE
    } state_t;

    // Length checks run at least two bits wider than either operand so the
    // "+2" on the remaining count can never wrap.
    localparam int              CMP_W   = ((LEN_W > 8) ? LEN_W : 8) + 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPTS);
    localparam logic [8:0]      VMAX    = 9'(MAX_VAL_BYTES);

    state_t                     state;
    state_t                     tail_state;
    logic [LEN_W-1:0]           rem;
    logic [LEN_W-1:0]           rem_after;
    logic                       last_byte;
    logic                       accept;
    logic [7:0]                 kind_q;
    logic [7:0]                 len_q;
    logic [7:0]                 vcnt;
    logic [7:0]                 vidx;
    logic [8*MAX_VAL_BYTES-1:0] val_buf;
    logic [8*MAX_VAL_BYTES-1:0] val_next;
    logic                       trunc_buf;
    logic                       trunc_next;
    logic                       len_short;
    logic                       len_over;

    // Input stalls whenever the record slot is full and not draining, so a
    // finished option can always be written into the slot.
    assign in_ready = ((state == S_INFO) || (state == S_LEN) ||
                       (state == S_DATA) || (state == S_END)) &&
                      (!opt_valid || opt_ready);
    assign accept     = in_valid && in_ready;
    // rem is nonzero in every byte-accepting state, so this never underflows
    // when it is actually used.
    assign rem_after  = rem - LEN_W'(1);
    assign last_byte  = (rem_after == '0);
    assign busy       = (state != S_READY);
    // After an EOL or an error, drain the rest of the area if any is left.
    assign tail_state = last_byte ? S_DONE : S_END;
    assign len_short  = (in_data < 8'd2);
    assign len_over   = CMP_W'(in_data) > (CMP_W'(rem_after) + CMP_W'(2));

    // Value accumulator with the current byte merged in, so the final byte
    // can go straight into the record slot on the same edge.
    always_comb begin
        val_next   = val_buf;
        trunc_next = trunc_buf;
        if ({1'b0, vidx} < VMAX) begin
            for (int i = 0; i < MAX_VAL_BYTES; i++) begin
                if (vidx == 8'(i)) begin
                    val_next[8*i +: 8] = in_data;
                end
            end
        end else begin
            trunc_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_READY;
            rem       <= '0;
            kind_q    <= '0;
            len_q     <= '0;
            vcnt      <= '0;
            vidx      <= '0;
            val_buf   <= '0;
            trunc_buf <= 1'b0;
            opt_valid <= 1'b0;
            opt_kind  <= '0;
            opt_len   <= '0;
            opt_value <= '0;
            opt_trunc <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            opt_count <= '0;
        end else begin
            done <= 1'b0;
            if (opt_valid && opt_ready) begin
                opt_valid <= 1'b0;
            end
            if (accept) begin
                rem <= rem_after;
            end

            case (state)
                S_READY: begin
                    if (start_i) begin
                        rem       <= total_len_i;
                        err       <= 1'b0;
                        err_code  <= '0;
                        opt_count <= '0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    state <= (rem == '0) ? S_DONE : S_INFO;
                end
                S_INFO: begin
                    if (accept) begin
                        if (in_data == 8'd0) begin
                            state <= tail_state;
                        end else if (in_data == 8'd1) begin
                            state <= last_byte ? S_DONE : S_INFO;
                            if (EMIT_NOP) begin
                                opt_valid <= 1'b1;
                                opt_kind  <= 8'd1;
                                opt_len   <= 8'd1;
                                opt_value <= '0;
                                opt_trunc <= 1'b0;
                            end
                        end else if (opt_count == MAX_CNT) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                            state    <= tail_state;
                        end else if (last_byte) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            state    <= S_DONE;
                        end else begin
                            kind_q <= in_data;
                            state  <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (len_short) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                            state    <= tail_state;
                        end else if (len_over) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            state    <= tail_state;
                        end else if (in_data == 8'd2) begin
                            opt_valid <= 1'b1;
                            opt_kind  <= kind_q;
                            opt_len   <= in_data;
                            opt_value <= '0;
                            opt_trunc <= 1'b0;
                            opt_count <= opt_count + CNT_W'(1);
                            state     <= last_byte ? S_DONE : S_INFO;
                        end else begin
                            len_q     <= in_data;
                            vcnt      <= in_data - 8'd2;
                            vidx      <= '0;
                            val_buf   <= '0;
                            trunc_buf <= 1'b0;
                            state     <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        val_buf   <= val_next;
                        trunc_buf <= trunc_next;
                        vidx      <= vidx + 8'd1;
                        vcnt      <= vcnt - 8'd1;
                        if (vcnt == 8'd1) begin
                            opt_valid <= 1'b1;
                            opt_kind  <= kind_q;
                            opt_len   <= len_q;
                            opt_value <= val_next;
                            opt_trunc <= trunc_next;
                            opt_count <= opt_count + CNT_W'(1);
                            state     <= last_byte ? S_DONE : S_INFO;
                        end
                    end
                end
                S_END: begin
                    if (accept && last_byte) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Completion is only signalled once the last record has
                    // been taken by the consumer.
                    if (!opt_valid) begin
                        done  <= 1'b1;
                        state <= S_READY;
                    end
                end
                default: state <= S_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_tlv_options_parser.sv
// tb_tlv_options_parser
// Directed bench for tlv_options_parser with default parameters. Expected
// records are queued when an area is driven and compared as the DUT hands
// records over; completion status is compared when done pulses.
module tb_tlv_options_parser;

    localparam int LEN_W = 6;
    localparam int VB    = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] total_len_i = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready;
    logic             opt_valid;
    logic             opt_ready = 1'b1;
    logic [7:0]       opt_kind;
    logic [7:0]       opt_len;
    logic [8*VB-1:0]  opt_value;
    logic             opt_trunc;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] opt_count;

    typedef struct {
        logic [7:0]  kind;
        logic [7:0]  len;
        logic [63:0] value;
        logic        trunc;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] area_q[$];
    int         checks = 0;
    int         errors = 0;

    tlv_options_parser #(
        .LEN_W(LEN_W), .MAX_VAL_BYTES(VB), .MAX_OPTS(8), .CNT_W(CNT_W), .EMIT_NOP(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .total_len_i(total_len_i),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .opt_valid(opt_valid), .opt_ready(opt_ready), .opt_kind(opt_kind),
        .opt_len(opt_len), .opt_value(opt_value), .opt_trunc(opt_trunc),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .opt_count(opt_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] k, input logic [7:0] l, input logic [63:0] v, input logic t);
        rec_t r;
        r.kind = k; r.len = l; r.value = v; r.trunc = t;
        exp_q.push_back(r);
    endtask

    // Scoreboard: every record handed over is compared with the oldest
    // expected record.
    always @(negedge clk) begin
        rec_t e;
        if (rst_n && opt_valid && opt_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_record", {56'd0, opt_kind}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check_output("rec_kind", {56'd0, opt_kind}, {56'd0, e.kind});
                check_output("rec_len", {56'd0, opt_len}, {56'd0, e.len});
                check_output("rec_value", opt_value, e.value);
                check_output("rec_trunc", {63'd0, opt_trunc}, {63'd0, e.trunc});
            end
        end
    end

    // Starts an area of len bytes and feeds the first nbytes of area_q.
    task automatic apply_stimulus(input logic [LEN_W-1:0] len, input int nbytes);
        @(posedge clk); #1;
        start_i = 1'b1;
        total_len_i = len;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            int waited;
            in_valid = 1'b1;
            in_data = area_q[i];
            waited = 0;
            @(negedge clk);
            while (!in_ready && waited < 200) begin
                waited++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check_output("in_ready_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits for the done pulse, then compares the completion status.
    task automatic wait_done(input string tag, input logic e_err, input logic [1:0] e_code, input logic [CNT_W-1:0] e_cnt);
        int waited = 0;
        @(negedge clk);
        while (!done && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check_output({tag, "_done"}, {63'd0, done}, 64'd1);
        check_output({tag, "_err"}, {63'd0, err}, {63'd0, e_err});
        check_output({tag, "_err_code"}, {62'd0, err_code}, {62'd0, e_code});
        check_output({tag, "_opt_count"}, {60'd0, opt_count}, {60'd0, e_cnt});
        check_output({tag, "_records_left"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check_output({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_output({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check_output({tag, "_opt_valid"}, {63'd0, opt_valid}, 64'd0);
        check_output({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_output({tag, "_done"}, {63'd0, done}, 64'd0);
        check_output({tag, "_err"}, {63'd0, err}, 64'd0);
        check_output({tag, "_err_code"}, {62'd0, err_code}, 64'd0);
        check_output({tag, "_opt_count"}, {60'd0, opt_count}, 64'd0);
        check_output({tag, "_fields"}, opt_value ^ {40'd0, opt_kind, opt_len, 7'd0, opt_trunc}, 64'd0);
    endtask

    task automatic load_area1();
        area_q = '{8'h02, 8'h04, 8'h05, 8'hB4, 8'h01, 8'h03, 8'h03, 8'h07,
                   8'h00, 8'h00, 8'h00, 8'h00};
        push_exp(8'h02, 8'h04, 64'hB405, 1'b0);
        push_exp(8'h03, 8'h03, 64'h07, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset.
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Empty area: done two cycles after start, no byte ever requested.
        @(posedge clk); #1;
        start_i = 1'b1;
        total_len_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check_output("empty_c1_done", {63'd0, done}, 64'd0);
        check_output("empty_c1_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check_output("empty_c2_done", {63'd0, done}, 64'd0);
        check_output("empty_c2_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check_output("empty_done", {63'd0, done}, 64'd1);
        check_output("empty_err", {63'd0, err}, 64'd0);
        check_output("empty_count", {60'd0, opt_count}, 64'd0);

        // Two options, a NOP, EOL and padding.
        load_area1();
        apply_stimulus(6'd12, 12);
        wait_done("area1", 1'b0, 2'd0, 4'd2);

        // Same area with the consumer stalled after the first record.
        load_area1();
        opt_ready = 1'b0;
        fork
            apply_stimulus(6'd12, 12);
            begin
                int waited = 0;
                @(negedge clk);
                while (!opt_valid && waited < 200) begin
                    waited++;
                    @(negedge clk);
                end
                for (int i = 0; i < 5; i++) begin
                    check_output("stall_in_ready", {63'd0, in_ready}, 64'd0);
                    check_output("stall_valid", {63'd0, opt_valid}, 64'd1);
                    check_output("stall_kind", {56'd0, opt_kind}, 64'h02);
                    check_output("stall_value", opt_value, 64'hB405);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                opt_ready = 1'b1;
            end
        join
        wait_done("stall", 1'b0, 2'd0, 4'd2);

        // Length runs past the end of the area: overrun, remainder drained.
        area_q = '{8'h08, 8'h0A, 8'h11, 8'h22};
        apply_stimulus(6'd4, 4);
        wait_done("overrun", 1'b1, 2'd2, 4'd0);

        // Length byte below 2.
        area_q = '{8'h05, 8'h01};
        apply_stimulus(6'd2, 2);
        wait_done("badlen", 1'b1, 2'd1, 4'd0);

        // Nine empty options against a limit of eight.
        area_q = {};
        for (int i = 0; i < 9; i++) begin
            area_q.push_back(8'h02);
            area_q.push_back(8'h02);
        end
        for (int i = 0; i < 8; i++) begin
            push_exp(8'h02, 8'h02, 64'h0, 1'b0);
        end
        apply_stimulus(6'd18, 18);
        wait_done("maxopts", 1'b1, 2'd3, 4'd8);

        // Ten value bytes: first eight kept, truncation flagged.
        area_q = {8'h07, 8'h0C};
        for (int i = 0; i < 10; i++) begin
            area_q.push_back(8'h10 + 8'(i));
        end
        push_exp(8'h07, 8'h0C, 64'h1716151413121110, 1'b1);
        apply_stimulus(6'd12, 12);
        wait_done("trunc", 1'b0, 2'd0, 4'd1);

        // Reset in the middle of a value, then a fresh area.
        area_q = '{8'h02, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h07, 8'h08};
        apply_stimulus(6'd10, 5);
        #2;
        rst_n = 1'b0;
        #2;
        check_idle_outputs("midreset");
        @(negedge clk);
        check_output("midreset_no_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        load_area1();
        apply_stimulus(6'd12, 12);
        wait_done("after_reset", 1'b0, 2'd0, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
